// File: rtl/tempo_ctrl.sv
// tempo_ctrl: converts tap periods from the period counter into beats-per-minute.
//
// A four-entry window of accepted tap periods is kept with a running sum. When
// the window changes, an iterative restoring divider computes
// PER_MAX*fill / sum. The result is saturated to BPM_MAX and offered on a
// valid/ready handshake. A timeout sample (or a zero period) clears the window
// and produces a result of 0, meaning "no tempo".
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous, active-high reset
//   per_i        measured tap period in time-pulse units, qualified by per_valid_i
//   per_valid_i  one-cycle strobe per button press
//   bpm_o        tempo result, 0 = no tempo
//   bpm_valid_o  result valid, held until accepted
//   bpm_ready_i  consumer ready
//   busy_o       high while the divider is running
module tempo_ctrl #(
  parameter int PER_MAX = 11718750,
  parameter int PER_W   = 24,
  parameter int BPM_W   = 9,
  parameter int BPM_MAX = 250
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [PER_W-1:0] per_i,
  input  logic             per_valid_i,
  output logic [BPM_W-1:0] bpm_o,
  output logic             bpm_valid_o,
  input  logic             bpm_ready_i,
  output logic             busy_o
);

  localparam int DEPTH = 4;
  localparam int SUM_W = PER_W + 2;
  localparam int NUM_W = PER_W + 3;
  localparam int CNT_W = $clog2(NUM_W);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  localparam logic [PER_W-1:0] PER_MAX_S = PER_W'(PER_MAX);
  localparam logic [NUM_W-1:0] PER_MAX_N = NUM_W'(PER_MAX);
  localparam logic [NUM_W-1:0] BPM_MAX_N = NUM_W'(BPM_MAX);
  localparam logic [BPM_W-1:0] BPM_MAX_B = BPM_W'(BPM_MAX);
  localparam logic [2:0]       FULL      = 3'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_W - 1);

  logic [PER_W-1:0] ring [DEPTH];
  logic [1:0]       wr_ptr;
  logic [2:0]       fill;
  logic [SUM_W-1:0] sum;
  logic             armed;
  logic             pend_zero;
  logic             pend_calc;

  logic [1:0]       state;
  logic [NUM_W-1:0] num;
  logic [SUM_W-1:0] den;
  logic [SUM_W-1:0] rem;
  logic [CNT_W-1:0] step;

  logic             zero_evt;
  logic             store_evt;
  logic [PER_W-1:0] evicted;
  logic             take_zero;
  logic             take_calc;
  logic [SUM_W:0]   trial;
  logic [SUM_W:0]   diff;
  logic             fits;
  logic [SUM_W-1:0] rem_next;
  logic [NUM_W-1:0] quot_next;

  // Classify the incoming strobe. A zero period can only come from a glitch
  // and is treated like a timeout so the divider never sees an empty sum.
  always_comb begin
    zero_evt  = per_valid_i && ((per_i == PER_MAX_S) || (per_i == '0));
    store_evt = per_valid_i && armed && !zero_evt;
    evicted   = (fill == FULL) ? ring[wr_ptr] : '0;
    take_zero = (state == ST_IDLE) && pend_zero;
    take_calc = (state == ST_IDLE) && !pend_zero && pend_calc;
  end

  // One restoring-division step: the dividend MSB shifts into the partial
  // remainder while the quotient bit shifts into the vacated LSB of num, so
  // num holds the full quotient after NUM_W steps.
  always_comb begin
    trial     = {rem, num[NUM_W-1]};
    diff      = trial - {1'b0, den};
    fits      = (trial >= {1'b0, den});
    rem_next  = fits ? diff[SUM_W-1:0] : trial[SUM_W-1:0];
    quot_next = {num[NUM_W-2:0], fits};
  end

  // Sample window and pending-request flags. A new request arriving in the
  // same cycle the FSM consumes the old one must survive, so set wins over
  // clear for both pend flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      sum       <= '0;
      armed     <= 1'b0;
      pend_zero <= 1'b0;
      pend_calc <= 1'b0;
    end else begin
      if (zero_evt) begin
        wr_ptr <= '0;
        fill   <= '0;
        sum    <= '0;
        armed  <= 1'b0;
      end else if (per_valid_i && !armed) begin
        armed <= 1'b1;
      end else if (store_evt) begin
        ring[wr_ptr] <= per_i;
        sum          <= sum - SUM_W'(evicted) + SUM_W'(per_i);
        fill         <= (fill == FULL) ? FULL : fill + 3'd1;
        wr_ptr       <= wr_ptr + 2'd1;
      end

      if (zero_evt)       pend_zero <= 1'b1;
      else if (take_zero) pend_zero <= 1'b0;

      if (store_evt)                   pend_calc <= 1'b1;
      else if (take_zero || take_calc) pend_calc <= 1'b0;
    end
  end

  // Compute sequencer. Operands are latched on leaving IDLE so the window may
  // keep changing while a division or an unaccepted result is in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      num   <= '0;
      den   <= '0;
      rem   <= '0;
      step  <= '0;
      bpm_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_zero) begin
            bpm_o <= '0;
            state <= ST_OUTPUT;
          end else if (take_calc) begin
            num   <= PER_MAX_N * NUM_W'(fill);
            den   <= sum;
            rem   <= '0;
            step  <= '0;
            state <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          num  <= quot_next;
          rem  <= rem_next;
          step <= step + CNT_W'(1);
          if (step == LAST_STEP) begin
            bpm_o <= (quot_next > BPM_MAX_N) ? BPM_MAX_B : quot_next[BPM_W-1:0];
            state <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          if (bpm_ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bpm_valid_o = (state == ST_OUTPUT);
  assign busy_o      = (state == ST_DIVIDE);

endmodule

// File: tb/tb_tempo_ctrl.sv
// tb_tempo_ctrl: scoreboard bench for tempo_ctrl.
//
// A small window model predicts each result; predictions are queued when the
// triggering sample is driven and popped when bpm_valid_o is seen. Inputs are
// driven and outputs sampled 1 ns after the rising clock edge.
module tb_tempo_ctrl;

  localparam int PER_MAX = 11718750;
  localparam int PER_W   = 24;
  localparam int BPM_W   = 9;
  localparam int BPM_MAX = 250;
  localparam int NUM_W   = PER_W + 3;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [PER_W-1:0] per_i;
  logic             per_valid_i;
  logic [BPM_W-1:0] bpm_o;
  logic             bpm_valid_o;
  logic             bpm_ready_i;
  logic             busy_o;

  int     checks = 0;
  int     errors = 0;
  int     exp_q[$];
  longint win[$];
  bit     armed_m;

  tempo_ctrl #(
    .PER_MAX(PER_MAX), .PER_W(PER_W), .BPM_W(BPM_W), .BPM_MAX(BPM_MAX)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .per_i       (per_i),
    .per_valid_i (per_valid_i),
    .bpm_o       (bpm_o),
    .bpm_valid_o (bpm_valid_o),
    .bpm_ready_i (bpm_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset();
    win.delete();
    armed_m = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_sample(input longint v);
    if (v == PER_MAX || v == 0) begin
      win.delete();
      armed_m = 1'b0;
    end else if (!armed_m) begin
      armed_m = 1'b1;
    end else begin
      win.push_back(v);
      if (win.size() > 4) void'(win.pop_front());
    end
  endtask

  function automatic int model_bpm();
    longint s = 0;
    longint q;
    foreach (win[i]) s += win[i];
    if (s == 0) return 0;
    q = (longint'(PER_MAX) * longint'(win.size())) / s;
    return (q > BPM_MAX) ? BPM_MAX : int'(q);
  endfunction

  task automatic send(input longint v);
    per_i       = PER_W'(v);
    per_valid_i = 1'b1;
    model_sample(v);
    tick();
    per_valid_i = 1'b0;
    per_i       = '0;
  endtask

  // Waits (bounded) for bpm_valid_o; cycles counts edges after the strobe edge.
  task automatic wait_valid(input int budget, output bit got, output int cycles,
                            output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    while (!bpm_valid_o && cycles < budget) begin
      tick();
      cycles++;
      if (busy_o) busy_cycles++;
    end
    got = bpm_valid_o;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    checks++;
    if ({bpm_o, bpm_valid_o, busy_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got bpm=%0d valid=%0b busy=%0b, expected all 0",
               bpm_o, bpm_valid_o, busy_o);
    end
    checks++;
    if (dut.fill !== 3'd0 || dut.sum !== '0 || dut.armed !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got fill=%0d sum=%0d armed=%0b, expected 0 0 0",
               dut.fill, dut.sum, dut.armed);
    end
    rst_i = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_first_tap();
    bit got; int cyc, bcyc;
    send(5000);
    wait_valid(100, got, cyc, bcyc);
    checks++;
    if (got !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_tap_no_result: got valid after %0d cycles, expected none", cyc);
    end
    checks++;
    if (dut.armed !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_tap_armed: got %0b expected 1", dut.armed);
    end
  endtask

  task automatic test_steady();
    bit got; int cyc, bcyc, exp;
    for (int i = 0; i < 4; i++) begin
      send(97656);
      exp_q.push_back(model_bpm());
      wait_valid(60, got, cyc, bcyc);
      exp = exp_q.pop_front();
      checks++;
      if (!got || bpm_o !== BPM_W'(exp)) begin
        errors++;
        $display("[TB] FAIL steady_bpm[%0d]: got valid=%0b bpm=%0d expected bpm=%0d",
                 i, got, bpm_o, exp);
      end
      checks++;
      if (cyc + 1 !== NUM_W + 2) begin
        errors++;
        $display("[TB] FAIL steady_latency[%0d]: got %0d cycles expected %0d", i, cyc + 1, NUM_W + 2);
      end
      checks++;
      if (bcyc !== NUM_W) begin
        errors++;
        $display("[TB] FAIL steady_busy[%0d]: got %0d busy cycles expected %0d", i, bcyc, NUM_W);
      end
      tick();
      checks++;
      if (bpm_valid_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL steady_valid_drop[%0d]: got %0b expected 0", i, bpm_valid_o);
      end
    end
    checks++;
    if (dut.sum !== 26'd390624 || dut.fill !== 3'd4) begin
      errors++;
      $display("[TB] FAIL steady_window: got sum=%0d fill=%0d expected 390624 4", dut.sum, dut.fill);
    end
  endtask

  task automatic test_mixed();
    bit got; int cyc, bcyc, exp;
    longint samples[2] = '{97656, 195312};
    do_reset();
    send(5000);
    for (int i = 0; i < 2; i++) begin
      send(samples[i]);
      exp_q.push_back(model_bpm());
      wait_valid(60, got, cyc, bcyc);
      exp = exp_q.pop_front();
      checks++;
      if (!got || bpm_o !== BPM_W'(exp)) begin
        errors++;
        $display("[TB] FAIL mixed_bpm[%0d]: got valid=%0b bpm=%0d expected bpm=%0d",
                 i, got, bpm_o, exp);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    bit got; int cyc, bcyc, exp;
    do_reset();
    send(5000);
    send(23437);
    exp_q.push_back(model_bpm());
    wait_valid(60, got, cyc, bcyc);
    exp = exp_q.pop_front();
    checks++;
    if (!got || bpm_o !== BPM_W'(exp)) begin
      errors++;
      $display("[TB] FAIL saturation_bpm: got valid=%0b bpm=%0d expected bpm=%0d", got, bpm_o, exp);
    end
    tick();
  endtask

  task automatic test_timeout();
    bit got; int cyc, bcyc, exp;
    send(PER_MAX);
    exp_q.push_back(0);
    wait_valid(10, got, cyc, bcyc);
    exp = exp_q.pop_front();
    checks++;
    if (!got || bpm_o !== BPM_W'(exp)) begin
      errors++;
      $display("[TB] FAIL timeout_bpm: got valid=%0b bpm=%0d expected bpm=%0d", got, bpm_o, exp);
    end
    checks++;
    if (cyc + 1 !== 2) begin
      errors++;
      $display("[TB] FAIL timeout_latency: got %0d cycles expected 2", cyc + 1);
    end
    tick();
    send(97656);
    wait_valid(60, got, cyc, bcyc);
    checks++;
    if (got !== 1'b0 || dut.fill !== 3'd0 || dut.armed !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_rearm: got valid=%0b fill=%0d armed=%0b expected 0 0 1",
               got, dut.fill, dut.armed);
    end
    send(97656);
    exp_q.push_back(model_bpm());
    wait_valid(60, got, cyc, bcyc);
    exp = exp_q.pop_front();
    checks++;
    if (!got || bpm_o !== BPM_W'(exp)) begin
      errors++;
      $display("[TB] FAIL timeout_resume_bpm: got valid=%0b bpm=%0d expected bpm=%0d", got, bpm_o, exp);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit got; int cyc, bcyc, exp;
    bpm_ready_i = 1'b0;
    send(97656);
    exp_q.push_back(model_bpm());
    wait_valid(60, got, cyc, bcyc);
    exp = exp_q.pop_front();
    checks++;
    if (!got || bpm_o !== BPM_W'(exp)) begin
      errors++;
      $display("[TB] FAIL bp_first_bpm: got valid=%0b bpm=%0d expected bpm=%0d", got, bpm_o, exp);
    end
    for (int c = 0; c < 50; c++) begin
      if (c == 5)       send(195312);
      else if (c == 15) send(48828);
      else if (c == 25) send(97656);
      else              tick();
      checks++;
      if (bpm_valid_o !== 1'b1 || bpm_o !== BPM_W'(exp)) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got valid=%0b bpm=%0d expected valid=1 bpm=%0d",
                 c, bpm_valid_o, bpm_o, exp);
      end
    end
    exp_q.push_back(model_bpm());
    bpm_ready_i = 1'b1;
    tick();
    checks++;
    if (bpm_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_accept_drop: got %0b expected 0", bpm_valid_o);
    end
    wait_valid(60, got, cyc, bcyc);
    exp = exp_q.pop_front();
    checks++;
    if (!got || bpm_o !== BPM_W'(exp)) begin
      errors++;
      $display("[TB] FAIL bp_recompute_bpm: got valid=%0b bpm=%0d expected bpm=%0d", got, bpm_o, exp);
    end
    tick();
    wait_valid(60, got, cyc, bcyc);
    checks++;
    if (got !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_single_recompute: got extra result bpm=%0d expected none", bpm_o);
    end
  endtask

  task automatic test_zero_wins();
    bit got; int cyc, bcyc, exp;
    send(48828);
    exp_q.push_back(model_bpm());
    tick();
    tick();
    send(97656);
    send(PER_MAX);
    exp_q.push_back(0);
    for (int r = 0; r < 2; r++) begin
      wait_valid(60, got, cyc, bcyc);
      exp = exp_q.pop_front();
      checks++;
      if (!got || bpm_o !== BPM_W'(exp)) begin
        errors++;
        $display("[TB] FAIL zero_wins_bpm[%0d]: got valid=%0b bpm=%0d expected bpm=%0d",
                 r, got, bpm_o, exp);
      end
      tick();
    end
    wait_valid(60, got, cyc, bcyc);
    checks++;
    if (got !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_wins_extra: got extra result bpm=%0d expected none", bpm_o);
    end
  endtask

  task automatic test_reset_mid_divide();
    bit got; int cyc, bcyc, exp, n;
    send(5000);
    send(97656);
    n = 0;
    while (!busy_o && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_divide_busy: got %0b expected 1", busy_o);
    end
    tick();
    tick();
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({bpm_o, bpm_valid_o, busy_o} !== '0 || dut.fill !== 3'd0 || dut.armed !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_divide_reset: got bpm=%0d valid=%0b busy=%0b fill=%0d armed=%0b expected all 0",
               bpm_o, bpm_valid_o, busy_o, dut.fill, dut.armed);
    end
    model_reset();
    tick();
    rst_i = 1'b0;
    tick();
    wait_valid(60, got, cyc, bcyc);
    checks++;
    if (got !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_divide_no_result: got result bpm=%0d expected none", bpm_o);
    end
    send(97656);
    wait_valid(60, got, cyc, bcyc);
    checks++;
    if (got !== 1'b0 || dut.armed !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_divide_rearm: got valid=%0b armed=%0b expected 0 1", got, dut.armed);
    end
    send(97656);
    exp_q.push_back(model_bpm());
    wait_valid(60, got, cyc, bcyc);
    exp = exp_q.pop_front();
    checks++;
    if (!got || bpm_o !== BPM_W'(exp)) begin
      errors++;
      $display("[TB] FAIL mid_divide_recover_bpm: got valid=%0b bpm=%0d expected bpm=%0d", got, bpm_o, exp);
    end
    tick();
  endtask

  initial begin
    rst_i       = 1'b1;
    per_i       = '0;
    per_valid_i = 1'b0;
    bpm_ready_i = 1'b1;
    model_reset();
    $display("[TB] tempo_ctrl bench start");
    test_reset();
    test_first_tap();
    test_steady();
    test_mixed();
    test_saturation();
    test_timeout();
    test_backpressure();
    test_zero_wins();
    test_reset_mid_divide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
